// File: rtl/fme_pkg.sv
// Shared types and constants for the FME half-pel window path.
package fme_pkg;

  localparam int WIN_STRIDE = 16;
  localparam int WIN_PIX    = WIN_STRIDE * WIN_STRIDE;
  localparam int HALF_N     = 9;

  typedef logic [7:0]                pix_t;
  typedef logic [HALF_N-1:0][7:0]    half_vec_t;
  typedef logic [WIN_PIX-1:0][7:0]   win_vec_t;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_RUN     = 2'd1,
    RD_RELEASE = 2'd2
  } rd_state_e;

  localparam pix_t LAST_IDX = pix_t'(WIN_PIX - 1);

endpackage

// File: rtl/fme_win_bank.sv
// One 256-pixel reference-window bank: single byte write port, whole bank read out packed.
module fme_win_bank
  import fme_pkg::*;
(
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [7:0]              waddr_i,
  input  logic [7:0]              wdata_i,
  output logic [WIN_PIX-1:0][7:0] rdata_o
);

  // Window storage is deliberately not reset; the full flags gate its use.
  win_vec_t mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/fme_win_loader.sv
// Ping-pong window loader for the half-pel interpolator: fills one bank from a raster
// stream while the other is presented to the interpolator, and latches its results.
module fme_win_loader
  import fme_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_pix,
  input  logic [7:0]        in_ctr,
  output logic [255:0][7:0] win,
  output logic [7:0]        win_ctr,
  output logic              ip_rst_n,
  input  logic              ip_done,
  input  logic [8:0][7:0]   ip_half,
  output logic [8:0][7:0]   res_half,
  output logic [7:0]        res_ctr,
  output logic              res_valid,
  output logic [15:0]       win_count
);

  rd_state_e           state_q, state_d;
  logic [1:0]          full_q;
  logic                wptr_q, rptr_q;
  pix_t                wcnt_q;
  logic [1:0][7:0]     ctr_q;
  logic [1:0][WIN_PIX-1:0][7:0] bank_rd;
  half_vec_t           res_half_q;
  pix_t                res_ctr_q;
  logic                res_valid_q;
  logic [15:0]         win_count_q;

  logic                accept;
  logic                capture;
  logic                release_win;
  logic [1:0]          bank_we;

  // ---------------------------------------------------------------- write side
  assign in_ready = !full_q[wptr_q];
  assign accept   = in_valid && in_ready && !flush;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = accept && (wptr_q == 1'(b));
    fme_win_bank u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .waddr_i (wcnt_q),
      .wdata_i (in_pix),
      .rdata_o (bank_rd[b])
    );
  end

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    state_d     = state_q;
    ip_rst_n    = 1'b0;
    capture     = 1'b0;
    release_win = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rptr_q]) state_d = RD_RUN;
      end
      RD_RUN: begin
        ip_rst_n = 1'b1;
        if (ip_done) begin
          capture = 1'b1;
          state_d = RD_RELEASE;
        end
      end
      RD_RELEASE: begin
        release_win = 1'b1;
        state_d     = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    if (flush) state_d = RD_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RD_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------- pointers, flags, results
  // flush drops every pending/partial window but keeps the last result and the window count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      wcnt_q      <= '0;
      ctr_q       <= '0;
      res_half_q  <= '0;
      res_ctr_q   <= '0;
      res_valid_q <= 1'b0;
      win_count_q <= '0;
    end else if (flush) begin
      full_q      <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      wcnt_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= capture;
      if (capture) begin
        res_half_q <= ip_half;
        res_ctr_q  <= ctr_q[rptr_q];
      end
      if (accept) begin
        wcnt_q <= wcnt_q + 8'd1;
        if (wcnt_q == '0) ctr_q[wptr_q] <= in_ctr;
        if (wcnt_q == LAST_IDX) begin
          full_q[wptr_q] <= 1'b1;
          wptr_q         <= ~wptr_q;
        end
      end
      // The writer can never be completing the bank being released: that bank is full.
      if (release_win) begin
        full_q[rptr_q] <= 1'b0;
        rptr_q         <= ~rptr_q;
        win_count_q    <= win_count_q + 16'd1;
      end
    end
  end

  assign win       = bank_rd[rptr_q];
  assign win_ctr   = ctr_q[rptr_q];
  assign res_half  = res_half_q;
  assign res_ctr   = res_ctr_q;
  assign res_valid = res_valid_q;
  assign win_count = win_count_q;

  // The interpolator only ever sees a full bank, and results only appear on release.
  a_read_bank_full: assert property (@(posedge clk) disable iff (!rst)
    (state_q != RD_IDLE) |-> full_q[rptr_q]);
  a_res_in_release: assert property (@(posedge clk) disable iff (!rst)
    res_valid_q |-> (state_q == RD_RELEASE));

endmodule
